// File: rtl/accel_stream_loader.sv
// Host-side sequencer: streams config beats, then instruction and input
// memory words (serialised LSB-chunk first) into the accelerator input link,
// and accepts/counts the accelerator's output beats until the expected
// number has arrived.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             one-cycle pulse; begins a load when not busy
//   num_instr         instruction word count (sampled at start)
//   num_inputs        input word count (sampled at start)
//   num_outputs       expected output beats (sampled at start)
//   cfg_data          NUM_CONFIGS config beats, beat k at [k*FIFO_WIDTH +: FIFO_WIDTH]
//   mem_ren/sel/addr  memory read request (sel 0 = instr, 1 = input)
//   mem_rdata         read data, valid one cycle after mem_ren
//   stream_*          ready/valid link toward the accelerator
//   out_data/vld/rdy  ready/valid link from the accelerator
//   cap_vld/data/idx  registered copy of the last accepted output beat
//   busy, done        load in progress / load complete (sticky)
module accel_stream_loader #(
    parameter int FIFO_WIDTH  = 16,
    parameter int WORD_WIDTH  = 32,
    parameter int NUM_CONFIGS = 5,
    parameter int ADDR_WIDTH  = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             num_instr,
    input  logic [ADDR_WIDTH-1:0]             num_inputs,
    input  logic [CNT_WIDTH-1:0]              num_outputs,
    input  logic [NUM_CONFIGS*FIFO_WIDTH-1:0] cfg_data,
    output logic                              mem_ren,
    output logic                              mem_sel,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [WORD_WIDTH-1:0]             mem_rdata,
    output logic [FIFO_WIDTH-1:0]             stream_data,
    output logic                              stream_vld,
    input  logic                              stream_rdy,
    input  logic [FIFO_WIDTH-1:0]             out_data,
    input  logic                              out_vld,
    output logic                              out_rdy,
    output logic                              cap_vld,
    output logic [FIFO_WIDTH-1:0]             cap_data,
    output logic [CNT_WIDTH-1:0]              cap_idx,
    output logic                              busy,
    output logic                              done
);

    localparam int CHUNKS = WORD_WIDTH / FIFO_WIDTH;
    localparam int CFG_W  = (NUM_CONFIGS > 1) ? $clog2(NUM_CONFIGS) : 1;
    localparam int CHK_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        FETCH,
        WAIT,
        SEND,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]             n_instr;
    logic [ADDR_WIDTH-1:0]             n_inputs;
    logic [CNT_WIDTH-1:0]              n_outputs;
    logic [NUM_CONFIGS*FIFO_WIDTH-1:0] cfg_sr;
    logic [CFG_W-1:0]                  cfg_idx;
    logic [WORD_WIDTH-1:0]             word_sr;
    logic [CHK_W-1:0]                  chunk_idx;
    logic [ADDR_WIDTH-1:0]             addr;
    logic [CNT_WIDTH-1:0]              out_count;
    logic                              phase;

    logic xfer;
    logic accept;
    logic cfg_last;
    logic chunk_last;
    logic phase_end;

    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);
    assign mem_sel    = phase;
    assign mem_addr   = addr;
    assign out_rdy    = busy && (out_count < n_outputs);
    assign xfer       = stream_vld && stream_rdy;
    assign accept     = out_vld && out_rdy;
    assign cfg_last   = (cfg_idx == CFG_W'(NUM_CONFIGS - 1));
    assign chunk_last = (chunk_idx == CHK_W'(CHUNKS - 1));
    // phase 0 walks the instruction region, phase 1 the input region
    assign phase_end  = (addr == (phase ? n_inputs : n_instr));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_ren     = 1'b0;
        stream_vld  = 1'b0;
        stream_data = '0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (NUM_CONFIGS == 0) ? FETCH : CFG;
                end
            end
            CFG: begin
                stream_vld  = 1'b1;
                stream_data = cfg_sr[FIFO_WIDTH-1:0];
                if (stream_rdy && cfg_last) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (phase_end) begin
                    // instr phase end flips to input phase and re-evaluates
                    if (phase) begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    mem_ren   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = SEND;
            end
            SEND: begin
                stream_vld  = 1'b1;
                stream_data = word_sr[FIFO_WIDTH-1:0];
                if (stream_rdy && chunk_last) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (out_count == n_outputs) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_instr   <= '0;
            n_inputs  <= '0;
            n_outputs <= '0;
            cfg_sr    <= '0;
            cfg_idx   <= '0;
            word_sr   <= '0;
            chunk_idx <= '0;
            addr      <= '0;
            out_count <= '0;
            phase     <= 1'b0;
            cap_vld   <= 1'b0;
            cap_data  <= '0;
            cap_idx   <= '0;
        end else begin
            cap_vld <= 1'b0;
            if (accept) begin
                cap_vld   <= 1'b1;
                cap_data  <= out_data;
                cap_idx   <= out_count;
                out_count <= out_count + CNT_WIDTH'(1);
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_instr   <= num_instr;
                        n_inputs  <= num_inputs;
                        n_outputs <= num_outputs;
                        cfg_sr    <= cfg_data;
                        cfg_idx   <= '0;
                        chunk_idx <= '0;
                        addr      <= '0;
                        out_count <= '0;
                        phase     <= 1'b0;
                    end
                end
                CFG: begin
                    if (xfer) begin
                        cfg_sr  <= cfg_sr >> FIFO_WIDTH;
                        cfg_idx <= cfg_idx + CFG_W'(1);
                    end
                end
                FETCH: begin
                    if (phase_end && !phase) begin
                        phase <= 1'b1;
                        addr  <= '0;
                    end
                end
                WAIT: begin
                    word_sr   <= mem_rdata;
                    chunk_idx <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        word_sr   <= word_sr >> FIFO_WIDTH;
                        chunk_idx <= chunk_idx + CHK_W'(1);
                        if (chunk_last) begin
                            addr <= addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_stream_loader.sv
// Self-checking bench for accel_stream_loader: randomized memory contents,
// ready/valid patterns and accelerator output beats vs. a queue-based model.
module tb_accel_stream_loader;

    localparam int FW = 16;
    localparam int WW = 32;
    localparam int NC = 5;
    localparam int AW = 12;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     num_instr;
    logic [AW-1:0]     num_inputs;
    logic [CW-1:0]     num_outputs;
    logic [NC*FW-1:0]  cfg_data;
    logic              mem_ren;
    logic              mem_sel;
    logic [AW-1:0]     mem_addr;
    logic [WW-1:0]     mem_rdata;
    logic [FW-1:0]     stream_data;
    logic              stream_vld;
    logic              stream_rdy;
    logic [FW-1:0]     out_data;
    logic              out_vld;
    logic              out_rdy;
    logic              cap_vld;
    logic [FW-1:0]     cap_data;
    logic [CW-1:0]     cap_idx;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    accel_stream_loader #(
        .FIFO_WIDTH(FW), .WORD_WIDTH(WW), .NUM_CONFIGS(NC),
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_instr(num_instr), .num_inputs(num_inputs),
        .num_outputs(num_outputs), .cfg_data(cfg_data),
        .mem_ren(mem_ren), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .stream_data(stream_data), .stream_vld(stream_vld),
        .stream_rdy(stream_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .cap_vld(cap_vld), .cap_data(cap_data), .cap_idx(cap_idx),
        .busy(busy), .done(done)
    );

    logic [WW-1:0]    imem [0:4095];
    logic [WW-1:0]    dmem [0:4095];
    logic [NC*FW-1:0] cfg_img;

    int n_pass = 0;
    int n_total = 0;

    logic [FW-1:0] got_q[$];
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] acc_q[$];
    logic [FW-1:0] cap_d_q[$];
    logic [CW-1:0] cap_i_q[$];
    int            accept_pos[$];

    int cyc, last_beat_cyc, done_cyc;
    int ren_count, sel0_reads, stab_bad, out_rdy_high, acc_ptr;
    int rdy_pct, vld_pct, stop_beat, bstart_beat;
    bit stop_hit, bstart_used, stab_pend, pend, pend_sel, vld_hold;
    logic [FW-1:0] stab_data;
    logic [AW-1:0] pend_addr;

    function automatic void build_exp(input int ni, input int nin);
        exp_q.delete();
        for (int k = 0; k < NC; k++) exp_q.push_back(cfg_img[k*FW +: FW]);
        for (int i = 0; i < ni; i++) begin
            exp_q.push_back(imem[i][15:0]);
            exp_q.push_back(imem[i][31:16]);
        end
        for (int i = 0; i < nin; i++) begin
            exp_q.push_back(dmem[i][15:0]);
            exp_q.push_back(dmem[i][31:16]);
        end
    endfunction

    function automatic int beat_mism();
        int m = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    function automatic int cap_mism();
        int m = 0;
        for (int j = 0; j < cap_d_q.size(); j++)
            if (cap_i_q[j] !== CW'(j) || cap_d_q[j] !== acc_q[j]) m++;
        return m;
    endfunction

    task automatic clear_obs();
        got_q.delete(); cap_d_q.delete(); cap_i_q.delete();
        accept_pos.delete(); acc_q.delete();
        for (int i = 0; i < 40; i++) acc_q.push_back(FW'($urandom));
        cyc = 0; last_beat_cyc = -1; done_cyc = -1;
        ren_count = 0; sel0_reads = 0; stab_bad = 0;
        out_rdy_high = 0; acc_ptr = 0;
        stop_beat = -1; bstart_beat = -1;
        stop_hit = 0; bstart_used = 0; stab_pend = 0;
        pend = 0; vld_hold = 0;
    endtask

    task automatic do_start(input int ni, input int nin, input int nout);
        @(negedge clk);
        num_instr   = AW'(ni);
        num_inputs  = AW'(nin);
        num_outputs = CW'(nout);
        cfg_data    = cfg_img;
        start       = 1'b1;
        stream_rdy  = 1'b0;
        out_vld     = 1'b0;
    endtask

    // one cycle: drive inputs at the negedge, then record what will
    // happen at the following posedge
    task automatic step();
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (bstart_beat >= 0 && !bstart_used && stream_vld &&
            got_q.size() == bstart_beat) begin
            start       = 1'b1;
            bstart_used = 1;
            num_instr   = AW'(2);
            num_inputs  = AW'(1);
            num_outputs = CW'(1);
            cfg_data    = '0;
        end
        stream_rdy = ($urandom_range(99) < rdy_pct);
        if (vld_hold) out_vld = 1'b1;
        else out_vld = (acc_ptr < acc_q.size()) &&
                       ($urandom_range(99) < vld_pct);
        out_data = out_vld ? acc_q[acc_ptr] : '0;
        if (pend) mem_rdata = pend_sel ? dmem[pend_addr] : imem[pend_addr];
        else mem_rdata = $urandom;
        pend = 0;
        #1;
        if (stream_vld && stop_beat >= 0 && got_q.size() == stop_beat) begin
            rst = 1'b1;
            stop_hit = 1;
            return;
        end
        if (stab_pend && !(stream_vld && stream_data === stab_data))
            stab_bad++;
        stab_pend = stream_vld && !stream_rdy;
        stab_data = stream_data;
        if (out_vld && out_rdy) begin
            accept_pos.push_back(got_q.size());
            acc_ptr++;
        end
        if (stream_vld && stream_rdy) begin
            got_q.push_back(stream_data);
            last_beat_cyc = cyc;
        end
        if (out_rdy) out_rdy_high++;
        if (mem_ren) begin
            ren_count++;
            if (!mem_sel) sel0_reads++;
            pend = 1; pend_sel = mem_sel; pend_addr = mem_addr;
        end
        if (cap_vld) begin
            cap_d_q.push_back(cap_data);
            cap_i_q.push_back(cap_idx);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        vld_hold = out_vld && !out_rdy;
    endtask

    task automatic run_load(output bit ok);
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (stop_hit || done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stream_rdy = 1'b0; out_vld = 1'b0;
        out_data = '0; mem_rdata = '0; cfg_data = '0;
        num_instr = '0; num_inputs = '0; num_outputs = '0;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_total++; if (stream_vld !== 1'b0) $display("FAIL reset_stream_vld got %b exp 0", stream_vld); else n_pass++;
        n_total++; if (mem_ren !== 1'b0) $display("FAIL reset_mem_ren got %b exp 0", mem_ren); else n_pass++;
        n_total++; if (out_rdy !== 1'b0) $display("FAIL reset_out_rdy got %b exp 0", out_rdy); else n_pass++;
        n_total++; if (cap_vld !== 1'b0) $display("FAIL reset_cap_vld got %b exp 0", cap_vld); else n_pass++;
        n_total++;
        if ({stream_data, mem_addr, mem_sel, cap_data, cap_idx} !== '0)
            $display("FAIL reset_buses got %h exp 0",
                     {stream_data, mem_addr, mem_sel, cap_data, cap_idx});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_full_load();
        bit ok;
        clear_obs(); rdy_pct = 100; vld_pct = 50;
        build_exp(126, 120);
        do_start(126, 120, 24);
        run_load(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL full_timeout got %b exp 1", ok); else n_pass++;
        n_total++; if (got_q.size() !== 497) $display("FAIL full_beat_count got %0d exp 497", got_q.size()); else n_pass++;
        n_total++; if (beat_mism() !== 0) $display("FAIL full_beat_data got %0d mismatches exp 0", beat_mism()); else n_pass++;
        n_total++; if (ren_count !== 246) $display("FAIL full_ren_count got %0d exp 246", ren_count); else n_pass++;
        n_total++; if (cap_d_q.size() !== 24) $display("FAIL full_cap_count got %0d exp 24", cap_d_q.size()); else n_pass++;
        n_total++; if (cap_mism() !== 0) $display("FAIL full_cap_data got %0d mismatches exp 0", cap_mism()); else n_pass++;
        n_total++; if ({done, busy} !== 2'b10) $display("FAIL full_done_busy got %b exp 10", {done, busy}); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_obs(); rdy_pct = 70; vld_pct = 30;
        build_exp(126, 120);
        do_start(126, 120, 24);
        run_load(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL bp_timeout got %b exp 1", ok); else n_pass++;
        n_total++; if (stab_bad !== 0) $display("FAIL bp_stability got %0d violations exp 0", stab_bad); else n_pass++;
        n_total++; if (got_q.size() !== 497) $display("FAIL bp_beat_count got %0d exp 497", got_q.size()); else n_pass++;
        n_total++; if (beat_mism() !== 0) $display("FAIL bp_beat_data got %0d mismatches exp 0", beat_mism()); else n_pass++;
        n_total++; if (ren_count !== 246) $display("FAIL bp_ren_count got %0d exp 246", ren_count); else n_pass++;
        n_total++; if (cap_d_q.size() !== 24 || cap_mism() !== 0)
            $display("FAIL bp_caps got %0d beats %0d bad exp 24 beats 0 bad", cap_d_q.size(), cap_mism());
        else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL bp_done got %b exp 1", done); else n_pass++;
    endtask

    task automatic test_zero_lengths();
        bit ok;
        clear_obs(); rdy_pct = 100; vld_pct = 100;
        build_exp(0, 3);
        do_start(0, 3, 0);
        run_load(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL zero_timeout got %b exp 1", ok); else n_pass++;
        n_total++; if (got_q.size() !== 11) $display("FAIL zero_beat_count got %0d exp 11", got_q.size()); else n_pass++;
        n_total++; if (beat_mism() !== 0) $display("FAIL zero_beat_data got %0d mismatches exp 0", beat_mism()); else n_pass++;
        n_total++; if (sel0_reads !== 0) $display("FAIL zero_instr_reads got %0d exp 0", sel0_reads); else n_pass++;
        n_total++; if (ren_count !== 3) $display("FAIL zero_ren_count got %0d exp 3", ren_count); else n_pass++;
        n_total++; if (out_rdy_high !== 0) $display("FAIL zero_out_rdy got %0d cycles exp 0", out_rdy_high); else n_pass++;
        n_total++; if (cap_d_q.size() !== 0) $display("FAIL zero_caps got %0d exp 0", cap_d_q.size()); else n_pass++;
        n_total++; if (done_cyc - last_beat_cyc !== 3)
            $display("FAIL zero_done_latency got %0d exp 3", done_cyc - last_beat_cyc);
        else n_pass++;
    endtask

    task automatic test_early_outputs();
        bit ok;
        int mx;
        clear_obs(); rdy_pct = 100; vld_pct = 100;
        build_exp(10, 8);
        do_start(10, 8, 4);
        run_load(ok);
        mx = 0;
        foreach (accept_pos[i]) if (accept_pos[i] > mx) mx = accept_pos[i];
        n_total++; if (ok !== 1'b1) $display("FAIL early_timeout got %b exp 1", ok); else n_pass++;
        n_total++; if (cap_d_q.size() !== 4 || cap_mism() !== 0)
            $display("FAIL early_caps got %0d beats %0d bad exp 4 beats 0 bad", cap_d_q.size(), cap_mism());
        else n_pass++;
        n_total++; if (accept_pos.size() !== 4 || mx >= NC)
            $display("FAIL early_in_cfg got %0d accepts last at beat %0d exp 4 before beat %0d", accept_pos.size(), mx, NC);
        else n_pass++;
        n_total++; if (out_rdy_high !== 4) $display("FAIL early_out_rdy got %0d cycles exp 4", out_rdy_high); else n_pass++;
        n_total++; if (got_q.size() !== 41 || beat_mism() !== 0)
            $display("FAIL early_beats got %0d beats %0d bad exp 41 beats 0 bad", got_q.size(), beat_mism());
        else n_pass++;
        n_total++; if (done_cyc - last_beat_cyc !== 3)
            $display("FAIL early_done_after_inputs got %0d exp 3", done_cyc - last_beat_cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int m;
        clear_obs(); rdy_pct = 100; vld_pct = 50;
        build_exp(126, 120);
        do_start(126, 120, 24);
        stop_beat = NC + 10 * 2 + 1;
        run_load(ok);
        m = 0;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) m++;
        n_total++; if (stop_hit !== 1'b1 || got_q.size() !== stop_beat || m !== 0)
            $display("FAIL rmid_prefix got %0d beats %0d bad exp %0d beats 0 bad", got_q.size(), m, stop_beat);
        else n_pass++;
        @(negedge clk);
        n_total++; if ({stream_vld, busy, done, mem_ren} !== 4'b0000)
            $display("FAIL rmid_after_rst got %b exp 0000", {stream_vld, busy, done, mem_ren});
        else n_pass++;
        rst = 1'b0;
        clear_obs();
        do_start(126, 120, 24);
        run_load(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rmid_timeout got %b exp 1", ok); else n_pass++;
        n_total++; if (got_q.size() !== 497 || beat_mism() !== 0)
            $display("FAIL rmid_replay got %0d beats %0d bad exp 497 beats 0 bad", got_q.size(), beat_mism());
        else n_pass++;
        n_total++; if (cap_d_q.size() !== 24 || cap_mism() !== 0)
            $display("FAIL rmid_caps got %0d beats %0d bad exp 24 beats 0 bad", cap_d_q.size(), cap_mism());
        else n_pass++;
    endtask

    task automatic test_busy_start();
        bit ok;
        clear_obs(); rdy_pct = 100; vld_pct = 50;
        build_exp(126, 120);
        do_start(126, 120, 24);
        bstart_beat = NC + 3 * 2;
        run_load(ok);
        n_total++; if ({ok, bstart_used} !== 2'b11) $display("FAIL busy_start_run got %b exp 11", {ok, bstart_used}); else n_pass++;
        n_total++; if (got_q.size() !== 497 || beat_mism() !== 0)
            $display("FAIL busy_start_beats got %0d beats %0d bad exp 497 beats 0 bad", got_q.size(), beat_mism());
        else n_pass++;
        n_total++; if (ren_count !== 246) $display("FAIL busy_start_ren got %0d exp 246", ren_count); else n_pass++;
        n_total++; if (cap_d_q.size() !== 24 || cap_mism() !== 0)
            $display("FAIL busy_start_caps got %0d beats %0d bad exp 24 beats 0 bad", cap_d_q.size(), cap_mism());
        else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL busy_start_done got %b exp 1", done); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            imem[i] = $urandom;
            dmem[i] = $urandom;
        end
        cfg_img = {16'h07e8, 16'h0017, 16'h07d0, 16'h0017, 16'h007d};
        test_reset();
        test_full_load();
        test_backpressure();
        test_zero_lengths();
        test_early_outputs();
        test_reset_mid();
        test_busy_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accel_stream_loader.md
Name: accel_stream_loader

Overview:
- Synthesizable host-side sequencer that feeds the accelerator's 16-bit ready/valid input link and drains its output link.
- Streams a boot image in three phases: config words, instruction words, input data words. Wide memory words are serialised into FIFO_WIDTH beats.
- Counts returned output beats and reports completion.
- Sits between on-chip SRAM / a wishbone-loaded buffer and the accelerator io pins; replaces the hand-written bench stimulus with a parametrised block.

Parameters:
- FIFO_WIDTH, 16, stream beat width (input and output links).
- WORD_WIDTH, 32, memory word width; must be an integer multiple of FIFO_WIDTH. CHUNKS = WORD_WIDTH/FIFO_WIDTH.
- NUM_CONFIGS, 5, number of config beats sent first.
- ADDR_WIDTH, 12, memory address width and instruction/input count width.
- CNT_WIDTH, 16, output beat counter width.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that begins a load; ignored while busy.
- num_instr, in, ADDR_WIDTH, instruction word count; sampled at start.
- num_inputs, in, ADDR_WIDTH, input word count; sampled at start.
- num_outputs, in, CNT_WIDTH, expected output beats; sampled at start.
- cfg_data, in, NUM_CONFIGS*FIFO_WIDTH, config beats; beat k = bits [k*FIFO_WIDTH +: FIFO_WIDTH]; sampled at start.
- mem_ren, out, 1, memory read enable.
- mem_sel, out, 1, 0 = instruction region, 1 = input region.
- mem_addr, out, ADDR_WIDTH, word address, 0-based per region.
- mem_rdata, in, WORD_WIDTH, read data, valid exactly 1 cycle after mem_ren.
- stream_data, out, FIFO_WIDTH, beat to accelerator.
- stream_vld, out, 1, beat valid.
- stream_rdy, in, 1, accelerator ready.
- out_data, in, FIFO_WIDTH, beat from accelerator.
- out_vld, in, 1, accelerator output valid.
- out_rdy, out, 1, loader accepts output beat.
- cap_vld, out, 1, registered: an output beat was accepted last cycle.
- cap_data, out, FIFO_WIDTH, registered accepted beat.
- cap_idx, out, CNT_WIDTH, 0-based index of that beat.
- busy, out, 1, load in progress.
- done, out, 1, load complete; sticky until next start or rst.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Transfers: a beat transfers when stream_vld && stream_rdy. Once raised, stream_vld and stream_data hold stable until transfer; stream_vld never drops without a transfer, except on rst.
- FSM states: IDLE, CFG, FETCH, WAIT, SEND, DRAIN, DONE.
- IDLE/DONE + start: latch sizes and cfg_data, clear done and counters, busy=1, go to CFG. If NUM_CONFIGS == 0, go to FETCH instead.
- CFG: present cfg beat k (k = 0..NUM_CONFIGS-1 in order). After the last transfer, go to FETCH with phase = INSTR.
- FETCH:
  - If the current phase count is exhausted: INSTR advances to the INPUT phase (address reset to 0) and stays in FETCH; INPUT goes to DRAIN.
  - Zero-length phases are skipped this way with no beats and no reads.
  - Otherwise pulse mem_ren for 1 cycle with mem_sel/mem_addr, then go to WAIT.
- WAIT: capture mem_rdata into the word register, then go to SEND.
- SEND: emit CHUNKS beats, chunk 0 = bits [FIFO_WIDTH-1:0] first (LSB first). After the last chunk transfers, addr++ and go to FETCH.
- Throughput: maximum is CHUNKS beats per CHUNKS+2 cycles; back-to-back words are not required.
- DRAIN: stream_vld=0; wait until output count == num_outputs, then DONE (busy=0, done=1).
- Output side:
  - out_rdy = busy && (out_count < num_outputs), in every state including CFG/SEND; early outputs are counted.
  - Accepted beat (out_vld && out_rdy): next cycle cap_vld=1, cap_data=beat, cap_idx=out_count; out_count++.
  - Beats beyond num_outputs are never accepted.
  - num_outputs == 0: DRAIN exits on its first cycle.
- start while busy: ignored, no state change. start in the same cycle as rst: rst wins.
- rst mid-operation: next cycle IDLE, stream_vld=0, mem_ren=0, busy=0, done=0. A beat being presented is dropped, not completed.
- Counters never wrap: num_instr/num_inputs max 2^ADDR_WIDTH-1.

Test Plan:
- Full load, stream_rdy=1, out_vld pattern supplied by model: NUM_CONFIGS=5, cfg {125,23,0x7d0,23,0x7e8}, num_instr=126, num_inputs=120, num_outputs=24.
  - First 5 beats = 0x007d,0x0017,0x07d0,0x0017,0x07e8.
  - Then 252 instr beats, then 240 input beats, all LSB-half first.
  - 24 cap beats, cap_idx 0..23; done=1.
- Backpressure: stream_rdy toggles pseudo-randomly with ~30% low.
  - stream_data stays stable while stream_vld=1 && !stream_rdy.
  - Beat sequence is identical to the scenario above.
  - mem_ren pulses exactly 246 times.
- Zero lengths: num_instr=0, num_inputs=3, num_outputs=0.
  - 5 cfg beats then 6 input beats.
  - mem_sel is always 1; out_rdy never high.
  - done 1 cycle after DRAIN entry.
- Early/excess outputs: out_vld=1 constantly from start, num_outputs=4.
  - Exactly 4 beats captured while still in CFG; out_rdy=0 afterwards.
  - done only after all input beats are sent.
- Reset mid-SEND of instr word 10, chunk 1: next cycle stream_vld=0, busy=0, done=0.
  - A new start replays from cfg beat 0 with the identical sequence.
- start pulsed while busy (at instr word 3): no effect; the sequence and final beat count are unchanged.
